// File: rtl/usb_tx_packetizer.sv
// EP6 slave-FIFO feeder: first-word fall-through word FIFO that tags each
// packet's final word for PKTEND, on a full packet or after an idle timeout.
module usb_tx_packetizer #(
  parameter int DEPTH     = 16,
  parameter int PKT_WORDS = 256,
  parameter int TIMEOUT   = 64
) (
  input  logic                       CLKOUT,
  input  logic                       rst,
  input  logic                       clr,
  input  logic [15:0]                in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [15:0]                out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 2);

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [15:0]   pkt_q, pkt_d;
  logic [TW-1:0] idle_q, idle_d;
  logic          ovf_q, ovf_d;
  logic          push, pop, flush_hit;

  assign in_ready  = (level_q < LW'(DEPTH)) && !clr;
  assign out_valid = (level_q != '0) && !clr;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Short-packet flush: only the last stored word, after a quiet producer.
  assign flush_hit = (TIMEOUT != 0)
                  && (level_q == LW'(1))
                  && (idle_q == TW'(TIMEOUT));

  assign out_last = out_valid
                 && ((pkt_q == 16'(PKT_WORDS - 1)) || flush_hit);

  assign out_data = out_valid ? mem_q[rd_ptr_q] : '0;
  assign level    = level_q;
  assign overflow = ovf_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    pkt_d    = pkt_q;
    idle_d   = idle_q;
    ovf_d    = ovf_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      pkt_d    = '0;
      idle_d   = '0;
      ovf_d    = 1'b0;
    end else begin
      if (in_valid && !in_ready)
        ovf_d = 1'b1;
      if (push)
        wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        pkt_d    = out_last ? 16'd0 : pkt_q + 16'd1;
      end
      unique case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      if (push)
        idle_d = '0;
      else if (idle_q != TW'(TIMEOUT))
        idle_d = idle_q + TW'(1);
    end
  end

  always_ff @(posedge CLKOUT or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      pkt_q    <= '0;
      idle_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      pkt_q    <= pkt_d;
      idle_q   <= idle_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge CLKOUT) begin
    if (push)
      mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_usb_tx_packetizer.sv
// Bench for usb_tx_packetizer: vector table, corner sequences,
// and randomized traffic against a queue-based packet model.
module tb_usb_tx_packetizer;

  localparam int DEPTH = 16;
  localparam int PKTW  = 4;
  localparam int TMO   = 8;

  logic        clk = 1'b0;
  logic        rst, clr;
  logic [15:0] in_data, out_data;
  logic        in_valid, in_ready;
  logic        out_valid, out_ready, out_last;
  logic [4:0]  level;
  logic        overflow;

  usb_tx_packetizer #(
    .DEPTH(DEPTH), .PKT_WORDS(PKTW), .TIMEOUT(TMO)
  ) dut (
    .CLKOUT(clk), .rst(rst), .clr(clr),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: stored words, words popped in this packet,
  // cycles since the last accepted word, sticky overflow.
  logic [15:0] mq[$];
  int          m_popped;
  int          m_since;
  bit          m_ovf;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic m_reset();
    mq.delete();
    m_popped = 0;
    m_since  = 0;
    m_ovf    = 1'b0;
  endtask

  // One clock: drive inputs, check outputs against the model,
  // take the edge, advance the model; returns at the next negedge.
  task automatic cyc(input bit c, input bit v, input logic [15:0] d,
                     input bit r);
    bit          e_rdy, e_vld, e_last, psh, pp;
    logic [15:0] e_dat;
    clr = c; in_valid = v; in_data = d; out_ready = r;
    #1;
    e_rdy  = (mq.size() < DEPTH) && !c;
    e_vld  = (mq.size() > 0) && !c;
    e_dat  = e_vld ? mq[0] : 16'h0;
    e_last = e_vld && (m_popped == PKTW - 1 ||
             (mq.size() == 1 && m_since >= TMO));
    chk("in_ready",  in_ready,  e_rdy);
    chk("out_valid", out_valid, e_vld);
    chk("out_data",  out_data,  e_dat);
    chk("out_last",  out_last,  e_last);
    chk("level",     level,     mq.size());
    chk("overflow",  overflow,  m_ovf);
    @(posedge clk);
    if (c) begin
      m_reset();
    end else begin
      psh = v && e_rdy;
      pp  = e_vld && r;
      if (v && !e_rdy) m_ovf = 1'b1;
      if (pp) begin
        m_popped = e_last ? 0 : m_popped + 1;
        void'(mq.pop_front());
      end
      if (psh) mq.push_back(d);
      if (psh) m_since = 0;
      else if (m_since < 1000) m_since++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  typedef struct {
    bit          v;
    logic [15:0] d;
    bit          r;
    int          lvl;
    bit          ov;
    logic [15:0] od;
    bit          ol;
    bit          ir;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{1'b1, 16'h0001, 1'b0, 1, 1'b1, 16'h0001, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 16'h0002, 1'b0, 2, 1'b1, 16'h0001, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 16'h0003, 1'b0, 3, 1'b1, 16'h0001, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 16'h0000, 1'b1, 2, 1'b1, 16'h0002, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 16'h0000, 1'b1, 1, 1'b1, 16'h0003, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 16'h0000, 1'b1, 0, 1'b0, 16'h0000, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 16'h000A, 1'b1, 1, 1'b1, 16'h000A, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 16'h0000, 1'b1, 0, 1'b0, 16'h0000, 1'b0, 1'b1};

    clr = 0; in_valid = 0; in_data = 0; out_ready = 0;
    do_reset();

    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last",  out_last,  0);
    chk("rst_out_data",  out_data,  0);
    chk("rst_level",     level,     0);
    chk("rst_overflow",  overflow,  0);

    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, tbl[i].v, tbl[i].d, tbl[i].r);
      chk($sformatf("tbl%0d_level", i), level,     tbl[i].lvl);
      chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ov);
      chk($sformatf("tbl%0d_data", i),  out_data,  tbl[i].od);
      chk($sformatf("tbl%0d_last", i),  out_last,  tbl[i].ol);
      chk($sformatf("tbl%0d_ready", i), in_ready,  tbl[i].ir);
    end

    // Short-packet flush after the producer goes quiet.
    do_reset();
    cyc(0, 1, 16'h0B01, 0);
    cyc(0, 1, 16'h0B02, 0);
    chk("tmo_w1_last", out_last, 0);
    cyc(0, 0, 16'h0, 1);
    for (int k = 0; k < 7; k++) begin
      chk("tmo_hold_last", out_last, 0);
      cyc(0, 0, 16'h0, 0);
    end
    chk("tmo_flush_last", out_last, 1);
    chk("tmo_flush_data", out_data, 16'h0B02);
    cyc(0, 0, 16'h0, 1);
    chk("tmo_empty", level, 0);

    // Fill to full, drop the 17th word, then push+pop at full.
    do_reset();
    for (int k = 0; k < 16; k++) cyc(0, 1, 16'h0100 + 16'(k), 0);
    chk("full_level", level, 16);
    chk("full_ready", in_ready, 0);
    cyc(0, 1, 16'h0110, 0);
    chk("drop_level", level, 16);
    chk("drop_ovf", overflow, 1);
    cyc(0, 1, 16'h0099, 1);
    chk("fullpp_level", level, 15);
    chk("fullpp_data", out_data, 16'h0101);
    for (int k = 0; k < 15; k++) cyc(0, 0, 16'h0, 1);
    chk("drain_level", level, 0);

    // clr mid-packet at level 5 with two words popped.
    for (int k = 0; k < 7; k++) cyc(0, 1, 16'h0200 + 16'(k), 0);
    cyc(0, 0, 16'h0, 1);
    cyc(0, 0, 16'h0, 1);
    chk("pre_clr_level", level, 5);
    cyc(1, 1, 16'h0300, 1);
    chk("clr_level", level, 0);
    chk("clr_ovf", overflow, 0);
    for (int k = 0; k < 4; k++) cyc(0, 1, 16'h0400 + 16'(k), 0);
    for (int k = 0; k < 4; k++) begin
      chk("clr_pkt_last", out_last, k == 3);
      cyc(0, 0, 16'h0, 1);
    end

    // Asynchronous reset between edges.
    for (int k = 0; k < 7; k++) cyc(0, 1, 16'h0500 + 16'(k), 0);
    chk("arst_pre_level", level, 7);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_level", level, 0);
    @(negedge clk);
    rst = 1'b0;
    m_reset();

    // Randomized traffic in phases of varying pressure.
    for (int ph = 0; ph < 24; ph++) begin
      int pv, pr;
      pv = $urandom_range(0, 4);
      pr = $urandom_range(0, 4);
      for (int k = 0; k < 100; k++) begin
        cyc($urandom_range(0, 63) == 0,
            $urandom_range(0, 3) < pv,
            16'($urandom),
            $urandom_range(0, 3) < pr);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
